sobel_edge: RTL and testbench
=============================

SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 SHALL have parameter LINE_MAX, default 1024, meaning the maximum pixels per line held in each line buffer.
REQ-002 SHALL have parameter COL_W, default 10, meaning the column-counter width, equal to clog2(LINE_MAX).
REQ-003 SHALL have ports: sys_clk input 1 (sole clock, rising edge); sys_rst input 1 (asynchronous, active-high reset).
REQ-004 SHALL have ports: per_frame_vsync input 1, per_frame_href input 1, per_frame_clken input 1 (input frame sync, line sync and pixel strobe).
REQ-005 SHALL have port gray_data input 24 (Y in [7:0], upper bytes ignored; the gray output of the colour-space stage).
REQ-006 SHALL have port edge_threshold input 11 (unsigned magnitude threshold, sampled every cycle).
REQ-007 SHALL have ports: post_frame_vsync, post_frame_href, post_frame_clken output 1 each; edge_data output 24 (binary edge image).

Function
REQ-008 SHALL accept a pixel only in a cycle with per_frame_href=1 and per_frame_clken=1 ("valid"); gaps within href SHALL stall the window without corrupting it.
REQ-009 SHALL keep a column counter that increments per valid pixel, clears on the href falling edge, and saturates at LINE_MAX-1.
REQ-010 SHALL keep a row counter that increments on each href falling edge, clears on the vsync rising edge, and saturates at 2.
REQ-011 SHALL use two cascaded line buffers addressed by the column counter with read-old-then-write: LB1 stores the current pixel and LB2 stores LB1's read data, both on valid only.
REQ-012 SHALL NOT write pixels at column index >= LINE_MAX, and SHALL force the output for those pixels to 0.
REQ-013 SHALL shift a 3x3 window on each valid pixel: the top row from LB2, the middle row from LB1, and the bottom row from the current pixel.
REQ-014 SHALL compute Gx = (p02+2p12+p22)-(p00+2p10+p20) and Gy = (p20+2p21+p22)-(p00+2p01+p02) as signed 11-bit values, range +/-1020, without overflow.
REQ-015 SHALL compute mag = |Gx|+|Gy| as unsigned 11-bit, max 2040, without saturation.
REQ-016 SHALL set edge = 1 when mag >= edge_threshold, giving edge_data 24'hFFFFFF, and 24'h000000 otherwise.
REQ-017 SHALL report the window centre for each output: the result tagged to input pixel (r,c) describes pixel (r-1,c-1), with no spatial re-alignment.
REQ-018 SHALL force the output to 0 for input pixels with row counter < 2 or column index < 2 (border suppression).
REQ-019 SHALL drive edge_data to 0 whenever post_frame_href=0.
REQ-020 SHALL have a latency of exactly 4 sys_clk cycles from a valid input sample to its edge_data, in these stages: line-buffer read; window register; Gx/Gy register; mag plus compare register.
REQ-021 SHALL delay vsync, href and clken through 4-stage shift registers so post_* stays cycle-aligned with edge_data.
REQ-022 SHALL use only one clock domain, with no combinational path from input to output.

Reset
REQ-023 SHALL, on sys_rst=1, asynchronously clear all counters, window, pipeline and sync registers, so all outputs read 0.
REQ-024 SHALL NOT clear line-buffer contents on reset; this is safe because row suppression (REQ-018) hides stale data.
REQ-025 SHALL, after release from a mid-frame reset, treat the first two lines seen as border, with outputs 0, until the next vsync rising edge restarts row counting.

Structure
REQ-026 SHALL take PIX_W=8, MAG_W=11, LATENCY=4 and the LINE_MAX default from a shared package, isp_pkg, reused by rgb2ycbcr's neighbours.
REQ-027 SHALL instantiate the sub-module line_buffer twice: a simple dual-port RAM with one write port, one registered read port, same address, and old-data read.
REQ-028 SHALL keep all other logic (counters, window, arithmetic, sync delay) in sobel_edge.

Verification
REQ-029 SHALL pass the flat-image test: a 16x8 frame with all Y=128 and threshold 1 -> edge_data 0 for every pixel, and post_frame_href exactly equal to per_frame_href delayed 4 cycles.
REQ-030 SHALL pass the vertical-step test: columns 0-7 at Y=0 and columns 8-15 at Y=255, threshold 100 -> FFFFFF only at input columns 8 and 9 on rows >= 2 (mag 1020), 0 elsewhere.
REQ-031 SHALL pass the threshold-boundary test: the same step with threshold 1020 -> FFFFFF at the same pixels; with threshold 1021 -> all 0.
REQ-032 SHALL pass the clken-gap test: the same step with clken deasserted every other cycle inside href -> an identical edge pattern, each result exactly 4 cycles after its valid input.
REQ-033 SHALL pass the reset test: sys_rst asserted at row 4, column 5 for 3 cycles -> all outputs 0 immediately; the next two lines are 0; the following frame matches the vertical-step result.
REQ-034 SHALL pass the overlength-line test: a line of LINE_MAX+4 pixels -> the last 4 outputs are 0, and the next line's results are uncorrupted.

Source files
------------

// File: rtl/isp_pkg.sv
// -----------------------------------------------------------------------------
// isp_pkg
// Shared constants, types and small helpers for the ISP pixel pipeline
// (rgb2ycbcr, sobel_edge and their neighbours).
//   PIX_W        : width of one luma sample
//   MAG_W        : width of gradient and magnitude values (signed Gx/Gy,
//                  unsigned |Gx|+|Gy|)
//   LATENCY      : input-to-output delay of sobel_edge in clock cycles
//   ISP_LINE_MAX : default maximum pixels per line held in a line buffer
// -----------------------------------------------------------------------------
package isp_pkg;

    localparam int PIX_W        = 8;
    localparam int MAG_W        = 11;
    localparam int LATENCY      = 4;
    localparam int ISP_LINE_MAX = 1024;

    typedef logic        [PIX_W-1:0] pix_t;
    typedef logic        [MAG_W-1:0] mag_t;
    typedef logic signed [MAG_W-1:0] grad_t;

    // One Sobel column or row term a + 2b + c. It is at most 4*255 = 1020,
    // so it fits in MAG_W-1 bits and becomes non-negative when zero-extended.
    function automatic logic [MAG_W-2:0] sobel_wsum(input pix_t a, input pix_t b, input pix_t c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // |v| for a gradient; the most negative value reached is -1020, so the
    // negation never overflows.
    function automatic mag_t grad_abs(input grad_t v);
        return v[MAG_W-1] ? mag_t'(-v) : mag_t'(v);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// Simple dual-port line memory: one write port and one registered read port
// that share a single address. A read and a write to the same address in the
// same cycle returns the previous contents (old-data read).
//   sys_clk : clock, rising edge
//   wr_en   : write wr_data into mem[addr]
//   rd_en   : load rd_data from mem[addr]; rd_data holds otherwise
//   addr    : shared read/write address
//   wr_data : data to store
//   rd_data : registered read data
// -----------------------------------------------------------------------------
module line_buffer #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the memory and its read register have no reset so the array maps
    // onto block RAM; stale contents are hidden downstream by border
    // suppression. Non-blocking writes give the old-data read behaviour.
    always_ff @(posedge sys_clk) begin
        if (rd_en) begin
            rd_data <= mem[addr];
        end
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_edge.sv
// -----------------------------------------------------------------------------
// sobel_edge
// 3x3 Sobel edge detector on a streamed gray image. Produces a binary edge
// image: 24'hFFFFFF where |Gx|+|Gy| >= edge_threshold, 24'h000000 otherwise.
// The result tagged to input pixel (r,c) describes the window centre
// (r-1,c-1). Outputs trail the inputs by exactly LATENCY cycles.
//   sys_clk          : clock, rising edge
//   sys_rst          : asynchronous active-high reset
//   per_frame_vsync  : input frame sync
//   per_frame_href   : input line sync
//   per_frame_clken  : input pixel strobe (pixel valid when href & clken)
//   gray_data        : Y in [7:0]; upper bytes ignored
//   edge_threshold   : unsigned magnitude threshold
//   post_frame_*     : syncs delayed to line up with edge_data
//   edge_data        : binary edge pixel
// -----------------------------------------------------------------------------
module sobel_edge
    import isp_pkg::*;
#(
    parameter int LINE_MAX = ISP_LINE_MAX,
    parameter int COL_W    = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [23:0] gray_data,
    input  logic [10:0] edge_threshold,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [23:0] edge_data
);

    // ---------------- input qualification and position counters -------------
    logic             pix_valid;
    pix_t             pix_in;
    logic             unused_gray_hi;
    logic             href_d, vsync_d;
    logic             href_fall, vsync_rise;
    logic [COL_W-1:0] col_cnt;
    logic             col_ovf;      // set once the line has passed LINE_MAX pixels
    logic             col_last;
    logic [1:0]       row_cnt;
    logic             border0;

    assign pix_valid      = per_frame_href & per_frame_clken;
    assign pix_in         = gray_data[PIX_W-1:0];
    assign unused_gray_hi = ^gray_data[23:PIX_W];
    assign href_fall      = href_d & ~per_frame_href;
    assign vsync_rise     = per_frame_vsync & ~vsync_d;
    assign col_last       = (col_cnt == COL_W'(LINE_MAX - 1));

    // First two rows, first two columns and overlength pixels have no full
    // 3x3 neighbourhood in the buffers, so their result is forced to 0.
    assign border0 = (row_cnt < 2'd2) | (col_cnt < COL_W'(2)) | col_ovf;

    // NOTE: every register in this design is written with non-blocking
    // assignments, so each stage samples the previous stage's pre-edge value.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            href_d  <= 1'b0;
            vsync_d <= 1'b0;
            col_cnt <= '0;
            col_ovf <= 1'b0;
            row_cnt <= '0;
        end else begin
            href_d  <= per_frame_href;
            vsync_d <= per_frame_vsync;

            // Column counter saturates at LINE_MAX-1; col_ovf marks every
            // later pixel of the same line as out of range.
            if (href_fall) begin
                col_cnt <= '0;
                col_ovf <= 1'b0;
            end else if (pix_valid) begin
                if (col_last) begin
                    col_ovf <= 1'b1;
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end

            if (vsync_rise) begin
                row_cnt <= '0;
            end else if (href_fall && (row_cnt != 2'd2)) begin
                row_cnt <= row_cnt + 2'd1;
            end
        end
    end

    // ---------------- stage 1: line-buffer read ------------------------------
    // LB1 holds the previous line. LB2 holds the line before that; it is
    // written one cycle later with LB1's registered old data at the same
    // column, so its own old-data read appears together with the window load.
    pix_t             lb1_q, lb2_q;
    logic             valid_s1, ovf_s1, border_s1;
    logic [COL_W-1:0] col_s1;
    pix_t             pix_s1;

    line_buffer #(
        .DEPTH  (LINE_MAX),
        .ADDR_W (COL_W),
        .DATA_W (PIX_W)
    ) u_lb1 (
        .sys_clk (sys_clk),
        .wr_en   (pix_valid & ~col_ovf),
        .rd_en   (pix_valid),
        .addr    (col_cnt),
        .wr_data (pix_in),
        .rd_data (lb1_q)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            valid_s1  <= 1'b0;
            ovf_s1    <= 1'b0;
            border_s1 <= 1'b1;
            col_s1    <= '0;
            pix_s1    <= '0;
        end else begin
            valid_s1  <= pix_valid;
            ovf_s1    <= col_ovf;
            border_s1 <= border0;
            col_s1    <= col_cnt;
            if (pix_valid) begin
                pix_s1 <= pix_in;
            end
        end
    end

    line_buffer #(
        .DEPTH  (LINE_MAX),
        .ADDR_W (COL_W),
        .DATA_W (PIX_W)
    ) u_lb2 (
        .sys_clk (sys_clk),
        .wr_en   (valid_s1 & ~ovf_s1),
        .rd_en   (valid_s1),
        .addr    (col_s1),
        .wr_data (lb1_q),
        .rd_data (lb2_q)
    );

    // ---------------- stage 2: 3x3 window ------------------------------------
    // pRC: R = row (0 top .. 2 bottom), C = column (0 oldest .. 2 newest).
    // The newest top-row tap p02 is LB2's read register itself.
    pix_t p00, p01, p02;
    pix_t p10, p11, p12;
    pix_t p20, p21, p22;
    logic valid_s2, border_s2;

    assign p02 = lb2_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            p00 <= '0; p01 <= '0;
            p10 <= '0; p11 <= '0; p12 <= '0;
            p20 <= '0; p21 <= '0; p22 <= '0;
            valid_s2  <= 1'b0;
            border_s2 <= 1'b1;
        end else begin
            valid_s2  <= valid_s1;
            border_s2 <= border_s1;
            // Gaps in clken leave the window untouched.
            if (valid_s1) begin
                p00 <= p01;   p01 <= lb2_q;
                p10 <= p11;   p11 <= p12;   p12 <= lb1_q;
                p20 <= p21;   p21 <= p22;   p22 <= pix_s1;
            end
        end
    end

    // ---------------- stage 3: gradients -------------------------------------
    grad_t gx_q, gy_q;
    logic  valid_s3, border_s3;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gx_q      <= '0;
            gy_q      <= '0;
            valid_s3  <= 1'b0;
            border_s3 <= 1'b1;
        end else begin
            valid_s3  <= valid_s2;
            border_s3 <= border_s2;
            if (valid_s2) begin
                gx_q <= $signed({1'b0, sobel_wsum(p02, p12, p22)})
                      - $signed({1'b0, sobel_wsum(p00, p10, p20)});
                gy_q <= $signed({1'b0, sobel_wsum(p20, p21, p22)})
                      - $signed({1'b0, sobel_wsum(p00, p01, p02)});
            end
        end
    end

    // ---------------- stage 4: magnitude and threshold -----------------------
    mag_t mag;
    logic edge_q;

    assign mag = grad_abs(gx_q) + grad_abs(gy_q);   // max 2040, fits MAG_W

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            edge_q <= 1'b0;
        end else begin
            // Only valid slots can carry an edge, so edge_data is 0 whenever
            // post_frame_href (or post_frame_clken) is low.
            edge_q <= valid_s3 & ~border_s3 & (mag >= edge_threshold);
        end
    end

    assign edge_data = {24{edge_q}};

    // ---------------- sync delay ---------------------------------------------
    logic [LATENCY-1:0] vsync_sr, href_sr, clken_sr;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vsync_sr <= '0;
            href_sr  <= '0;
            clken_sr <= '0;
        end else begin
            vsync_sr <= {vsync_sr[LATENCY-2:0], per_frame_vsync};
            href_sr  <= {href_sr[LATENCY-2:0],  per_frame_href};
            clken_sr <= {clken_sr[LATENCY-2:0], per_frame_clken};
        end
    end

    assign post_frame_vsync = vsync_sr[LATENCY-1];
    assign post_frame_href  = href_sr[LATENCY-1];
    assign post_frame_clken = clken_sr[LATENCY-1];

endmodule

// File: tb/tb_sobel_edge.sv
// -----------------------------------------------------------------------------
// tb_sobel_edge
// Scoreboard bench for sobel_edge. Stimulus pushes the hand-derived expected
// edge bit of every valid pixel; a monitor pops and compares whenever the DUT
// presents a valid output, and also checks the 4-cycle latency.
// -----------------------------------------------------------------------------
module tb_sobel_edge;

    localparam int LINE_MAX  = 32;
    localparam int COL_W     = 5;
    localparam int PAT_FLAT  = 0;
    localparam int PAT_VSTEP = 1;
    localparam int PAT_HSTEP = 2;
    localparam int PAT_IMP   = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        per_frame_vsync = 1'b0;
    logic        per_frame_href  = 1'b0;
    logic        per_frame_clken = 1'b0;
    logic [23:0] gray_data       = '0;
    logic [10:0] edge_threshold  = '0;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [23:0] edge_data;

    sobel_edge #(
        .LINE_MAX (LINE_MAX),
        .COL_W    (COL_W)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .gray_data        (gray_data),
        .edge_threshold   (edge_threshold),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .edge_data        (edge_data)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit exp_edge;
        int cyc;
        int row;
        int col;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         chk_sync = 1'b0;
    logic [3:0] href_sh  = '0;

    always @(posedge sys_clk) begin
        cyc     <= cyc + 1;
        href_sh <= {href_sh[2:0], per_frame_href};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (post_frame_href && post_frame_clken) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: output %h with no pending pixel (t=%0t)", edge_data, $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("edge r%0d c%0d", e.row, e.col), {8'h00, edge_data},
                          e.exp_edge ? 32'h00FF_FFFF : 32'h0);
                    check($sformatf("latency r%0d c%0d", e.row, e.col), cyc - e.cyc, 4);
                end
            end
            if (chk_sync) begin
                check("post_href_dly", 32'(post_frame_href), 32'(href_sh[3]));
                if (!post_frame_href) begin
                    check("idle_zero", {8'h00, edge_data}, 0);
                end
            end
        end
    end

    // ---------------- hand-derived stimulus and expectations ----------------
    function automatic logic [7:0] pix_val(input int pat, input int r, input int c);
        case (pat)
            PAT_FLAT:  return 8'd128;
            PAT_VSTEP: return (c >= 8 && c < LINE_MAX) ? 8'd255 : 8'd0;
            PAT_HSTEP: return (r >= 4) ? 8'd255 : 8'd0;
            PAT_IMP:   return (r == 4 && c == 6) ? 8'd200 : 8'd0;
            default:   return 8'd0;
        endcase
    endfunction

    // Vertical step: windows at input cols 8,9 straddle the step, mag 1020.
    // Horizontal step: windows at input rows 4,5 straddle it, mag 1020.
    // Impulse 200 at (4,6): every non-centre window position gives mag 400.
    function automatic bit exp_val(input int pat, input int r, input int c, input int thr_v);
        if (r < 2 || c < 2 || c >= LINE_MAX) return 1'b0;
        case (pat)
            PAT_VSTEP: return (c == 8 || c == 9) && (thr_v <= 1020);
            PAT_HSTEP: return (r == 4 || r == 5) && (thr_v <= 1020);
            PAT_IMP:   return (r >= 4 && r <= 6 && c >= 6 && c <= 8 && !(r == 5 && c == 7))
                              && (thr_v <= 400);
            default:   return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_pixel(input int pat, input int r, input int c, input int thr_v);
        per_frame_clken = 1'b1;
        gray_data       = {16'hC3C3, pix_val(pat, r, c)};
        sb_q.push_back('{exp_val(pat, r, c, thr_v), cyc, r, c});
        tick();
    endtask

    task automatic send_line(input int pat, input int r, input int width, input bit gap, input int thr_v);
        per_frame_href = 1'b1;
        for (int c = 0; c < width; c++) begin
            if (gap) begin
                per_frame_clken = 1'b0;
                gray_data       = 24'hEEEEEE;
                tick();
            end
            drive_pixel(pat, r, c, thr_v);
        end
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        gray_data       = '0;
        idle(4);
    endtask

    task automatic start_frame(input int thr_v);
        edge_threshold  = 11'(thr_v);
        per_frame_vsync = 1'b1;
        idle(2);
        per_frame_vsync = 1'b0;
        idle(2);
    endtask

    task automatic send_frame(input int pat, input int rows, input int width, input bit gap, input int thr_v);
        start_frame(thr_v);
        for (int r = 0; r < rows; r++) send_line(pat, r, width, gap, thr_v);
        idle(4);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_vsync"}, 32'(post_frame_vsync), 0);
        check({tag, "_href"},  32'(post_frame_href),  0);
        check({tag, "_clken"}, 32'(post_frame_clken), 0);
        check({tag, "_data"},  {8'h00, edge_data},    0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        check_outputs_zero("reset");
        sys_rst = 1'b0;
        idle(2);

        // Flat image, plus exact 4-cycle delay of href
        chk_sync = 1'b1;
        send_frame(PAT_FLAT, 8, 16, 1'b0, 1);
        chk_sync = 1'b0;

        // Vertical step and threshold boundary
        send_frame(PAT_VSTEP, 8, 16, 1'b0, 100);
        send_frame(PAT_VSTEP, 8, 16, 1'b0, 1020);
        send_frame(PAT_VSTEP, 8, 16, 1'b0, 1021);

        // clken gaps inside href
        send_frame(PAT_VSTEP, 8, 16, 1'b1, 100);

        // Horizontal step (Gy path) and impulse (kernel weights)
        send_frame(PAT_HSTEP, 8, 16, 1'b0, 100);
        send_frame(PAT_IMP,   8, 16, 1'b0, 400);
        send_frame(PAT_IMP,   8, 16, 1'b0, 401);

        // Mid-frame reset at row 4, column 5
        start_frame(100);
        for (int r = 0; r < 4; r++) send_line(PAT_VSTEP, r, 16, 1'b0, 100);
        per_frame_href = 1'b1;
        for (int c = 0; c <= 5; c++) drive_pixel(PAT_VSTEP, 4, c, 100);
        sys_rst         = 1'b1;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        gray_data       = '0;
        #1;
        check_outputs_zero("midrst");
        sb_q.delete();   // pixels in flight are discarded by the reset
        idle(3);
        sys_rst = 1'b0;
        idle(3);
        // The next two lines count as rows 0 and 1: all border
        send_line(PAT_VSTEP, 0, 16, 1'b0, 100);
        send_line(PAT_VSTEP, 1, 16, 1'b0, 100);
        idle(4);
        send_frame(PAT_VSTEP, 8, 16, 1'b0, 100);

        // Overlength lines: LINE_MAX+4 pixels each
        send_frame(PAT_VSTEP, 4, LINE_MAX + 4, 1'b0, 100);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
        check("sb_drain", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
